// File: rtl/registros_multi.sv
// Register bank shared by N_CH req/ack requesters, serialised by a round-robin arbiter.
// Out-of-range addresses and writes to read-only registers complete with err set.
module registros_multi #(
    parameter int unsigned     DATA_W  = 16,
    parameter int unsigned     ADDR_W  = 8,
    parameter int unsigned     DEPTH   = 32,
    parameter int unsigned     N_CH    = 2,
    parameter logic [DEPTH-1:0] RO_MASK = '0
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic [N_CH-1:0]          req,
    input  logic [N_CH-1:0]          RNW,
    input  logic [N_CH*ADDR_W-1:0]   ADDR,
    input  logic [N_CH*DATA_W-1:0]   WR_DATA,
    output logic [DATA_W-1:0]        RD_DATA,
    output logic [N_CH-1:0]          ack,
    output logic                     err,
    output logic                     busy
);

    localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ACCESS    = 2'd1;
    localparam logic [1:0] WAIT_DROP = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [CH_W-1:0]   ptr;
    logic [CH_W-1:0]   grant;
    logic [CH_W-1:0]   pick;
    logic              found;
    int                rr_idx;
    logic              lat_rnw;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic [DATA_W-1:0] regs [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic              is_ro;

    // Round-robin search starting at the priority pointer
    always_comb begin
        found  = 1'b0;
        pick   = ptr;
        rr_idx = 0;
        for (int i = 0; i < int'(N_CH); i++) begin
            rr_idx = int'(ptr) + i;
            if (rr_idx >= int'(N_CH)) rr_idx = rr_idx - int'(N_CH);
            if (!found && req[CH_W'(rr_idx)]) begin
                found = 1'b1;
                pick  = CH_W'(rr_idx);
            end
        end
    end

    // Address decode of the latched request; compare one bit wider so DEPTH = 2^ADDR_W works
    always_comb begin
        idx      = IDX_W'(lat_addr);
        in_range = ({1'b0, lat_addr} < (ADDR_W + 1)'(DEPTH));
        is_ro    = RO_MASK[idx];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (found) state_next = ACCESS;
            ACCESS:    state_next = WAIT_DROP;
            WAIT_DROP: if (!req[grant]) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            ptr      <= '0;
            grant    <= '0;
            lat_rnw  <= 1'b0;
            lat_addr <= '0;
            lat_data <= '0;
            ack      <= '0;
            err      <= 1'b0;
            RD_DATA  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) regs[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant    <= pick;
                        ptr      <= (pick == CH_W'(N_CH - 1)) ? '0 : pick + CH_W'(1);
                        lat_rnw  <= RNW[pick];
                        lat_addr <= ADDR[pick*ADDR_W +: ADDR_W];
                        lat_data <= WR_DATA[pick*DATA_W +: DATA_W];
                    end
                end
                ACCESS: begin
                    ack <= N_CH'(1) << grant;
                    if (!in_range) begin
                        err <= 1'b1;
                        if (lat_rnw) RD_DATA <= '0;
                    end else if (lat_rnw) begin
                        RD_DATA <= regs[idx];
                        err     <= 1'b0;
                    end else if (is_ro) begin
                        err <= 1'b1;
                    end else begin
                        regs[idx] <= lat_data;
                        err       <= 1'b0;
                    end
                end
                WAIT_DROP: begin
                    if (!req[grant]) begin
                        ack <= '0;
                        err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_registros_multi.sv
// Randomised bench for registros_multi against a transaction-level model of the register bank.
module tb_registros_multi;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned N_CH   = 2;
    localparam logic [DEPTH-1:0] RO = 32'h0000_0004;

    logic                   CLK = 1'b0;
    logic                   Reset;
    logic [N_CH-1:0]        req_v;
    logic [N_CH-1:0]        rnw_v;
    logic [N_CH*ADDR_W-1:0] addr_v;
    logic [N_CH*DATA_W-1:0] wdata_v;
    logic [DATA_W-1:0]      rd_data;
    logic [N_CH-1:0]        ack;
    logic                   err;
    logic                   busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] mregs [DEPTH];
    logic [DATA_W-1:0] mrd;
    int                mptr;

    registros_multi #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .N_CH   (N_CH),
        .RO_MASK(RO)
    ) dut (
        .CLK    (CLK),
        .Reset  (Reset),
        .req    (req_v),
        .RNW    (rnw_v),
        .ADDR   (addr_v),
        .WR_DATA(wdata_v),
        .RD_DATA(rd_data),
        .ack    (ack),
        .err    (err),
        .busy   (busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Effect of one access on the model; returns expected err and RD_DATA afterwards
    task automatic model_access(input bit rnw, input int a, input logic [15:0] d,
                                output bit e, output logic [15:0] rd);
        if (a >= int'(DEPTH)) begin
            e = 1'b1;
            if (rnw) mrd = '0;
        end else if (rnw) begin
            e   = 1'b0;
            mrd = mregs[a];
        end else if (RO[a]) begin
            e = 1'b1;
        end else begin
            e        = 1'b0;
            mregs[a] = d;
        end
        rd = mrd;
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) mregs[i] = '0;
        mrd  = '0;
        mptr = 0;
    endtask

    task automatic drive(input int ch, input bit rnw, input int a, input logic [15:0] d);
        req_v[ch] = 1'b1;
        rnw_v[ch] = rnw;
        addr_v[ch*ADDR_W +: ADDR_W]  = ADDR_W'(a);
        wdata_v[ch*DATA_W +: DATA_W] = d;
    endtask

    task automatic wait_ack(input int ch, input int start, output int cyc);
        cyc = start;
        while (ack[ch] !== 1'b1 && cyc < 20) begin
            @(posedge CLK); #1;
            cyc++;
        end
    endtask

    // Check the response, optionally hold req, then drop req and check the release
    task automatic finish_txn(input int ch, input bit e, input logic [15:0] rd, input int hold);
        check("ack_onehot", 32'(ack), 32'(1) << ch);
        check("err", 32'(err), 32'(e));
        check("rd_data", 32'(rd_data), 32'(rd));
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK); #1;
            check("ack_hold", 32'(ack), 32'(1) << ch);
        end
        @(negedge CLK);
        req_v[ch] = 1'b0;
        @(posedge CLK); #1;
        check("ack_release", 32'(ack[ch]), 32'd0);
        check("err_release", 32'(err), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    // Single request on an idle bank; inputs are scrambled after the grant edge
    task automatic single(input int ch, input bit rnw, input int a, input logic [15:0] d, input int hold);
        bit          e;
        logic [15:0] rd;
        int          cyc;
        @(negedge CLK);
        drive(ch, rnw, a, d);
        model_access(rnw, a, d, e, rd);
        mptr = (ch + 1) % int'(N_CH);
        @(posedge CLK); #1;
        check("busy_access", 32'(busy), 32'd1);
        check("ack_early", 32'(ack), 32'd0);
        @(negedge CLK);
        drive(ch, ~rnw, a ^ 5, ~d);
        wait_ack(ch, 1, cyc);
        check("latency", 32'(cyc), 32'd2);
        finish_txn(ch, e, rd, hold);
    endtask

    // Both channels request on the same edge; the model pointer decides the order
    task automatic pair(input bit r0, input int a0, input logic [15:0] d0,
                        input bit r1, input int a1, input logic [15:0] d1, input int hold);
        bit          rw [2];
        int          aa [2];
        logic [15:0] dd [2];
        bit          ef, es;
        logic [15:0] rf, rs;
        int          f, s, cyc;
        rw[0] = r0; aa[0] = a0; dd[0] = d0;
        rw[1] = r1; aa[1] = a1; dd[1] = d1;
        @(negedge CLK);
        drive(0, r0, a0, d0);
        drive(1, r1, a1, d1);
        f = mptr;
        s = 1 - f;
        model_access(rw[f], aa[f], dd[f], ef, rf);
        model_access(rw[s], aa[s], dd[s], es, rs);
        mptr = (s + 1) % int'(N_CH);
        wait_ack(f, 0, cyc);
        check("pair_first_lat", 32'(cyc), 32'd2);
        finish_txn(f, ef, rf, hold);
        wait_ack(s, 0, cyc);
        check("pair_second_lat", 32'(cyc), 32'd2);
        finish_txn(s, es, rs, 0);
    endtask

    // req dropped while the access is in flight: ack lasts exactly one cycle
    task automatic violation(input int ch, input bit rnw, input int a, input logic [15:0] d);
        bit          e;
        logic [15:0] rd;
        @(negedge CLK);
        drive(ch, rnw, a, d);
        model_access(rnw, a, d, e, rd);
        mptr = (ch + 1) % int'(N_CH);
        @(posedge CLK); #1;
        @(negedge CLK);
        req_v[ch] = 1'b0;
        @(posedge CLK); #1;
        check("viol_ack", 32'(ack), 32'(1) << ch);
        check("viol_err", 32'(err), 32'(e));
        check("viol_rd", 32'(rd_data), 32'(rd));
        @(posedge CLK); #1;
        check("viol_release", 32'(ack), 32'd0);
        check("viol_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset   = 1'b0;
        req_v   = '0;
        rnw_v   = '0;
        addr_v  = '0;
        wdata_v = '0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd", 32'(rd_data), 32'd0);
        @(negedge CLK);
        Reset = 1'b1;

        single(0, 1'b0, 3, 16'h00A5, 0);
        single(0, 1'b1, 3, 16'h0000, 0);
        single(1, 1'b1, 3, 16'h0000, 0);
        pair(1'b0, 5, 16'h1111, 1'b0, 5, 16'h2222, 0);
        single(0, 1'b1, 5, 16'h0000, 0);
        pair(1'b1, 3, 16'h0000, 1'b1, 5, 16'h0000, 0);

        single(0, 1'b1, 32, 16'h0000, 0);
        single(1, 1'b0, 40, 16'h5A5A, 0);
        single(0, 1'b1, 8, 16'h0000, 0);
        single(1, 1'b1, 5, 16'h0000, 0);

        single(0, 1'b0, 2, 16'hFFFF, 0);
        single(0, 1'b1, 2, 16'h0000, 0);

        pair(1'b1, 3, 16'h0000, 1'b0, 9, 16'h9999, 4);
        violation(1, 1'b1, 9, 16'h0000);

        single(0, 1'b0, 7, 16'h1234, 0);
        @(negedge CLK);
        drive(0, 1'b0, 7, 16'hBEEF);
        @(posedge CLK); #1;
        check("busy_before_rst", 32'(busy), 32'd1);
        Reset = 1'b0;
        #1;
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rd", 32'(rd_data), 32'd0);
        model_reset();
        @(negedge CLK);
        req_v = '0;
        @(negedge CLK);
        Reset = 1'b1;
        single(0, 1'b1, 7, 16'h0000, 0);

        for (int it = 0; it < 40; it++) begin
            int unsigned sel;
            sel = $urandom_range(0, 3);
            if (sel < 2) begin
                single(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 9)), 16'($urandom), int'($urandom_range(0, 2)));
            end else if (sel == 2) begin
                pair(1'($urandom_range(0, 1)), int'($urandom_range(0, 9)), 16'($urandom),
                     1'($urandom_range(0, 1)), int'($urandom_range(0, 9)), 16'($urandom),
                     int'($urandom_range(0, 2)));
            end else begin
                pair(1'($urandom_range(0, 1)), int'($urandom_range(0, 40)), 16'($urandom),
                     1'($urandom_range(0, 1)), int'($urandom_range(0, 40)), 16'($urandom), 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
